// File: rtl/div_pkg.sv
// Shared peripheral definitions for the divider: FSM encoding, the divide-by-zero
// quotient code and the packed-result field layout common with the multiplier.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StStep = 2'd2,
    StEnd  = 2'd3
  } div_state_e;

  localparam logic [15:0] DIV_ZERO_QUOT = 16'hFFFF;

  // Packed result: {high field, low field}; for div: {remainder, quotient}.
  localparam int unsigned RES_FIELD_W  = 16;
  localparam int unsigned RES_QUOT_LSB = 0;
  localparam int unsigned RES_REM_LSB  = 16;

endpackage

// File: rtl/div.sv
// Sequential 16-bit unsigned restoring divider, one quotient bit per clock,
// with the init/done handshake and {remainder, quotient} packed result.
module div
  import div_pkg::*;
#(
  parameter int unsigned DONE_HOLD = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic [15:0] op_A,
  input  logic [15:0] op_B,
  output logic        done,
  output logic [31:0] result,
  output logic        div_zero
);

  localparam int unsigned HoldW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  div_state_e       state_q, state_d;
  logic [15:0]      q_q, q_d;
  logic [15:0]      d_q, d_d;
  // R[16] is always zero between steps, so only the low 16 bits are stored;
  // the trial value below keeps the full 17 bits for the compare.
  logic [15:0]      r_q, r_d;
  logic [3:0]       step_q, step_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             done_q, done_d;
  logic [31:0]      result_q, result_d;
  logic             div_zero_q, div_zero_d;

  logic [16:0] trial;
  logic        qbit;
  logic [15:0] r_next;
  logic [15:0] q_next;

  // Trial subtract: T - D fits in 16 bits whenever T >= D since R < D.
  assign trial  = {r_q, q_q[15]};
  assign qbit   = (trial >= {1'b0, d_q});
  assign r_next = qbit ? (trial[15:0] - d_q) : trial[15:0];
  assign q_next = {q_q[14:0], qbit};

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    d_d        = d_q;
    r_d        = r_q;
    step_d     = step_q;
    hold_d     = hold_q;
    done_d     = done_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        done_d = 1'b0;
        step_d = '0;
        if (init) state_d = StLoad;
      end
      StLoad: begin
        q_d      = op_A;
        d_d      = op_B;
        r_d      = '0;
        result_d = '0;
        step_d   = '0;
        hold_d   = '0;
        if (op_B == 16'd0) begin
          result_d[RES_REM_LSB +: RES_FIELD_W]  = op_A;
          result_d[RES_QUOT_LSB +: RES_FIELD_W] = DIV_ZERO_QUOT;
          div_zero_d = 1'b1;
          done_d     = 1'b1;
          state_d    = StEnd;
        end else begin
          div_zero_d = 1'b0;
          state_d    = StStep;
        end
      end
      StStep: begin
        r_d    = r_next;
        q_d    = q_next;
        step_d = step_q + 4'd1;
        if (step_q == 4'd15) begin
          result_d[RES_REM_LSB +: RES_FIELD_W]  = r_next;
          result_d[RES_QUOT_LSB +: RES_FIELD_W] = q_next;
          done_d  = 1'b1;
          state_d = StEnd;
        end
      end
      StEnd: begin
        done_d = 1'b1;
        if (hold_q == HoldW'(DONE_HOLD - 1)) begin
          done_d  = 1'b0;
          hold_d  = '0;
          state_d = StIdle;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      q_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      step_q     <= '0;
      hold_q     <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      d_q        <= d_d;
      r_q        <= r_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign done     = done_q;
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule
